// File: rtl/frame_buf_arbiter.sv
// Arbitrates one single-ported frame memory between a pixel writer and a display
// reader, and double-buffers the frame so that buffer swaps never tear.
module frame_buf_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  pll0_pll_clk_clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  wr_frame_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_frame_start,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en_n,
  output logic                  mem_rd_en_n,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  buf_sel,
  output logic                  swap_pending,
  output logic                  swap_done
);

  localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_e;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } grant_e;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  buf_sel_q, buf_sel_d;
  logic                  swap_pending_q, swap_pending_d;
  logic                  sof_q, sof_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  swap_done_q, swap_done_d;
  logic                  mem_wr_en_n_q, mem_wr_en_n_d;
  logic                  mem_rd_en_n_q, mem_rd_en_n_d;
  logic [ADDR_WIDTH:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic wr_elig;
  logic grant_wr;

  // Writes stall behind a pending swap; on contention the port not served last wins.
  assign wr_elig  = wr_req && !swap_pending_q;
  assign grant_wr = wr_elig && (!rd_req || (last_grant_q == GNT_READ));

  always_ff @(posedge pll0_pll_clk_clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GNT_READ;
      cnt_q          <= '0;
      buf_sel_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      sof_q          <= 1'b0;
      wr_ack_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      rd_valid_q     <= 1'b0;
      swap_done_q    <= 1'b0;
      mem_wr_en_n_q  <= 1'b1;
      mem_rd_en_n_q  <= 1'b1;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      buf_sel_q      <= buf_sel_d;
      swap_pending_q <= swap_pending_d;
      sof_q          <= sof_d;
      wr_ack_q       <= wr_ack_d;
      rd_ack_q       <= rd_ack_d;
      rd_valid_q     <= rd_valid_d;
      swap_done_q    <= swap_done_d;
      mem_wr_en_n_q  <= mem_wr_en_n_d;
      mem_rd_en_n_q  <= mem_rd_en_n_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      rd_data_q      <= rd_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    buf_sel_d      = buf_sel_q;
    swap_pending_d = swap_pending_q;
    sof_d          = sof_q;
    wr_ack_d       = 1'b0;
    rd_ack_d       = 1'b0;
    rd_valid_d     = 1'b0;
    swap_done_d    = 1'b0;
    mem_wr_en_n_d  = 1'b1;
    mem_rd_en_n_d  = 1'b1;
    mem_addr_d     = mem_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    rd_data_d      = rd_data_q;

    // A reader start-of-frame only counts once the writer has finished its frame.
    if (rd_frame_start && swap_pending_q) begin
      sof_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (swap_pending_q && sof_q) begin
          buf_sel_d      = ~buf_sel_q;
          swap_pending_d = 1'b0;
          sof_d          = 1'b0;
          swap_done_d    = 1'b1;
        end else if (grant_wr) begin
          state_d       = ST_WRITE;
          last_grant_d  = GNT_WRITE;
          mem_addr_d    = {buf_sel_q, wr_addr};
          mem_wr_data_d = wr_data;
          mem_wr_en_n_d = 1'b0;
          wr_ack_d      = 1'b1;
        end else if (rd_req) begin
          state_d       = ST_READ;
          last_grant_d  = GNT_READ;
          mem_addr_d    = {~buf_sel_q, rd_addr};
          mem_rd_en_n_d = 1'b0;
          rd_ack_d      = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        state_d = ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_RD_WAIT: begin
        // Memory data lands on the final wait cycle.
        if (cnt_q == CNT_LAST) begin
          rd_data_d  = mem_rd_data;
          rd_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new frame-done in the swap cycle re-arms the next swap.
    if (wr_frame_done) begin
      swap_pending_d = 1'b1;
    end
  end

  assign wr_ack       = wr_ack_q;
  assign rd_ack       = rd_ack_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_wr_en_n  = mem_wr_en_n_q;
  assign mem_rd_en_n  = mem_rd_en_n_q;
  assign buf_sel      = buf_sel_q;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Bench for frame_buf_arbiter: transaction-level scheduling model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_frame_buf_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 19;
  localparam int unsigned L  = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, wr_frame_done, rd_req, rd_frame_start;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, rd_ack, rd_valid;
  logic [DW-1:0] rd_data, mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic [AW:0]   mem_addr;
  logic          mem_wr_en_n, mem_rd_en_n, buf_sel, swap_pending, swap_done;

  int checks   = 0;
  int failures = 0;

  frame_buf_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
    .pll0_pll_clk_clk(clk),
    .reset(reset),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .wr_frame_done(wr_frame_done),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_frame_start(rd_frame_start),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_en_n(mem_wr_en_n),
    .mem_rd_en_n(mem_rd_en_n),
    .mem_rd_data(mem_rd_data),
    .buf_sel(buf_sel),
    .swap_pending(swap_pending),
    .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom(input logic [AW:0] a);
    if (a == 20'h80005) return 32'h12345678;
    return {12'hA5A, a};
  endfunction

  // Read-only memory with one cycle of registered read latency.
  always @(posedge clk) begin
    if (!mem_rd_en_n) mem_rd_data <= rom(mem_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected per-cycle events held in a small calendar indexed by cycle number.
  bit            s_wr [16];
  bit            s_rd [16];
  bit            s_rv [16];
  bit            s_sw [16];
  logic [AW:0]   s_addr [16];
  logic [DW-1:0] s_wd [16];
  logic [DW-1:0] s_rdat [16];
  int            cyc = 0;
  int            m_busy = 0;
  bit            m_pend, m_sof, m_buf, m_last_w, m_on, m_rstchk;
  logic [DW-1:0] m_rdata;

  always @(posedge clk) begin
    int n, v;
    bit np, ns, nb, we;
    logic [AW:0] a;
    n = (cyc + 1) % 16;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        s_wr[i] = 0; s_rd[i] = 0; s_rv[i] = 0; s_sw[i] = 0;
      end
      m_busy = 0; m_pend = 0; m_sof = 0; m_buf = 0; m_last_w = 0;
      m_rdata = '0; m_on = 1; m_rstchk = 1;
    end else if (m_on) begin
      m_rstchk = 0;
      np = m_pend; ns = m_sof; nb = m_buf;
      if (rd_frame_start && m_pend) ns = 1;
      if (m_busy > 0) begin
        m_busy--;
      end else if (m_pend && m_sof) begin
        nb = !m_buf; np = 0; ns = 0; s_sw[n] = 1;
      end else begin
        we = wr_req && !m_pend;
        if (we && (!rd_req || !m_last_w)) begin
          s_wr[n] = 1; s_addr[n] = {m_buf, wr_addr}; s_wd[n] = wr_data;
          m_busy = 1; m_last_w = 1;
        end else if (rd_req) begin
          a = {!m_buf, rd_addr};
          s_rd[n] = 1; s_addr[n] = a;
          v = (cyc + 2 + L) % 16;
          s_rv[v] = 1; s_rdat[v] = rom(a);
          m_busy = 1 + L; m_last_w = 0;
        end
      end
      if (wr_frame_done) np = 1;
      m_pend = np; m_sof = ns; m_buf = nb;
      if (s_rv[n]) m_rdata = s_rdat[n];
    end
    cyc++;
  end

  always @(negedge clk) begin
    int k;
    if (m_on) begin
      k = cyc % 16;
      chk("m_wr_ack", 64'(wr_ack), 64'(s_wr[k]));
      chk("m_rd_ack", 64'(rd_ack), 64'(s_rd[k]));
      chk("m_rd_valid", 64'(rd_valid), 64'(s_rv[k]));
      chk("m_swap_done", 64'(swap_done), 64'(s_sw[k]));
      chk("m_wr_en_n", 64'(mem_wr_en_n), 64'(!s_wr[k]));
      chk("m_rd_en_n", 64'(mem_rd_en_n), 64'(!s_rd[k]));
      chk("m_buf_sel", 64'(buf_sel), 64'(m_buf));
      chk("m_swap_pending", 64'(swap_pending), 64'(m_pend));
      chk("m_rd_data", 64'(rd_data), 64'(m_rdata));
      if (s_wr[k] || s_rd[k]) chk("m_mem_addr", 64'(mem_addr), 64'(s_addr[k]));
      if (s_wr[k]) chk("m_mem_wr_data", 64'(mem_wr_data), 64'(s_wd[k]));
      if (m_rstchk) begin
        chk("m_rst_addr", 64'(mem_addr), 64'd0);
        chk("m_rst_wdata", 64'(mem_wr_data), 64'd0);
      end
      s_wr[k] = 0; s_rd[k] = 0; s_rv[k] = 0; s_sw[k] = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_ack"}, 64'(wr_ack), 64'd0);
    chk({tag, "_rd_ack"}, 64'(rd_ack), 64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wr_data"}, 64'(mem_wr_data), 64'd0);
    chk({tag, "_wr_en_n"}, 64'(mem_wr_en_n), 64'd1);
    chk({tag, "_rd_en_n"}, 64'(mem_rd_en_n), 64'd1);
    chk({tag, "_buf_sel"}, 64'(buf_sel), 64'd0);
    chk({tag, "_swap_pending"}, 64'(swap_pending), 64'd0);
    chk({tag, "_swap_done"}, 64'(swap_done), 64'd0);
  endtask

  initial begin
    int nw, nr, ov;
    reset = 1; wr_req = 0; rd_req = 0; wr_frame_done = 0; rd_frame_start = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    step(3);
    chk_reset_vals("rst0");
    reset = 0;
    step(1);

    // Single write
    wr_req = 1; wr_addr = 19'd5; wr_data = 32'hDEADBEEF;
    step(1);
    chk("w1_ack", 64'(wr_ack), 64'd1);
    chk("w1_addr", 64'(mem_addr), 64'h00005);
    chk("w1_en", 64'(mem_wr_en_n), 64'd0);
    chk("w1_data", 64'(mem_wr_data), 64'hDEADBEEF);
    wr_req = 0;
    step(1);
    chk("w1_ack_off", 64'(wr_ack), 64'd0);
    chk("w1_en_off", 64'(mem_wr_en_n), 64'd1);

    // Single read from the other buffer
    rd_req = 1; rd_addr = 19'd5;
    step(1);
    chk("r1_ack", 64'(rd_ack), 64'd1);
    chk("r1_addr", 64'(mem_addr), 64'h80005);
    chk("r1_en", 64'(mem_rd_en_n), 64'd0);
    rd_req = 0;
    step(1);
    chk("r1_valid_early", 64'(rd_valid), 64'd0);
    step(1);
    chk("r1_valid", 64'(rd_valid), 64'd1);
    chk("r1_data", 64'(rd_data), 64'h12345678);

    // Both ports held: W,R,W,R ...
    wr_req = 1; wr_addr = 19'd7; wr_data = 32'h11111111;
    rd_req = 1; rd_addr = 19'd9;
    nw = 0; nr = 0; ov = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (i == 0) chk("rr_first_is_write", 64'(wr_ack), 64'd1);
      nw += int'(wr_ack);
      nr += int'(rd_ack);
      if (!mem_wr_en_n && !mem_rd_en_n) ov++;
    end
    wr_req = 0; rd_req = 0;
    chk("rr_writes", 64'(nw), 64'd3);
    chk("rr_reads", 64'(nr), 64'd3);
    chk("rr_overlap", 64'(ov), 64'd0);

    // Frame done stalls writes until reader start-of-frame swaps buffers
    wr_frame_done = 1; step(1); wr_frame_done = 0;
    chk("sw_pending", 64'(swap_pending), 64'd1);
    wr_req = 1; wr_addr = 19'd3; wr_data = 32'hCAFE0003;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("sw_stall", 64'(wr_ack), 64'd0);
    end
    rd_frame_start = 1; step(1); rd_frame_start = 0;
    chk("sw_stall_sof", 64'(wr_ack), 64'd0);
    step(1);
    chk("sw_done", 64'(swap_done), 64'd1);
    chk("sw_buf_sel", 64'(buf_sel), 64'd1);
    chk("sw_pending_clr", 64'(swap_pending), 64'd0);
    step(1);
    chk("sw_wr_ack", 64'(wr_ack), 64'd1);
    chk("sw_wr_addr", 64'(mem_addr), 64'h80003);
    wr_req = 0;

    // Start-of-frame during a read wait defers the swap to the next idle cycle
    wr_frame_done = 1; step(1); wr_frame_done = 0;
    chk("df_pending", 64'(swap_pending), 64'd1);
    rd_req = 1; rd_addr = 19'd5;
    step(1);
    chk("df_rd_ack", 64'(rd_ack), 64'd1);
    chk("df_rd_addr", 64'(mem_addr), 64'h00005);
    rd_req = 0;
    step(1);
    rd_frame_start = 1; step(1); rd_frame_start = 0;
    chk("df_valid", 64'(rd_valid), 64'd1);
    chk("df_data", 64'(rd_data), 64'hA5A00005);
    chk("df_buf_held", 64'(buf_sel), 64'd1);
    chk("df_no_swap", 64'(swap_done), 64'd0);
    step(1);
    chk("df_swap", 64'(swap_done), 64'd1);
    chk("df_buf", 64'(buf_sel), 64'd0);

    // Reset during a read wait abandons the read
    wr_frame_done = 1; step(1); wr_frame_done = 0;
    rd_frame_start = 1; step(1); rd_frame_start = 0;
    step(1);
    chk("rw_buf_pre", 64'(buf_sel), 64'd1);
    rd_req = 1; rd_addr = 19'd2;
    step(1);
    chk("rw_rd_ack", 64'(rd_ack), 64'd1);
    chk("rw_rd_addr", 64'(mem_addr), 64'h00002);
    rd_req = 0;
    step(1);
    reset = 1;
    step(1);
    chk_reset_vals("rst1");
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rw_no_valid", 64'(rd_valid), 64'd0);
    end

    // Frame done coinciding with the swap re-arms the next swap
    wr_frame_done = 1; step(1); wr_frame_done = 0;
    rd_frame_start = 1; step(1); rd_frame_start = 0;
    wr_frame_done = 1; step(1); wr_frame_done = 0;
    chk("sw2_done", 64'(swap_done), 64'd1);
    chk("sw2_buf", 64'(buf_sel), 64'd1);
    chk("sw2_rearm", 64'(swap_pending), 64'd1);
    rd_frame_start = 1; step(1); rd_frame_start = 0;
    step(1);
    chk("sw3_done", 64'(swap_done), 64'd1);
    chk("sw3_buf", 64'(buf_sel), 64'd0);
    chk("sw3_pending", 64'(swap_pending), 64'd0);

    // Mixed traffic with frame events, requests held until acknowledged
    for (int i = 0; i < 60; i++) begin
      if (wr_req && wr_ack) wr_req = 0;
      else if (!wr_req && (i % 4) != 3) begin
        wr_req = 1; wr_addr = AW'(i * 3); wr_data = 32'h50000000 + DW'(i);
      end
      if (rd_req && rd_ack) rd_req = 0;
      else if (!rd_req && (i % 3) == 0) begin
        rd_req = 1; rd_addr = AW'(i + 100);
      end
      wr_frame_done  = (i == 15 || i == 40);
      rd_frame_start = (i == 25 || i == 33 || i == 50);
      step(1);
    end
    wr_req = 0; rd_req = 0; wr_frame_done = 0; rd_frame_start = 0;
    step(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
